est_somador_nbits: RTL
======================

Name: est_somador_nbits

Overview:
- Parametrised, clocked successor of the 4-bit dual-rail NCL adder stage.
- Adds two WIDTH-digit dual-rail operands with a dual-rail carry-in, with add/subtract mode and a dual-rail carry-out.
- Registers the result under a four-phase DATA/NULL handshake with the next stage, and flags illegal rail codes and stalled handshakes.
- Sits between dual-rail pipeline registers in the datapath, driving ack upstream and consuming ack_next from downstream.

Parameters:
- WIDTH, 4, number of logical bits; every dual-rail bus is 2*WIDTH wires.
- STALL_MAX, 255, cycles without a phase change, with non-NULL input present, before stall asserts (≥1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  2*WIDTH  operand A, dual-rail; digit i on [2i+1:2i].
- b  in  2*WIDTH  operand B, dual-rail.
- opr  in  2  carry-in, dual-rail.
- mode  in  2  dual-rail; logic 0 = add, logic 1 = subtract.
- ack_next  in  1  downstream phase: 0 = ready for DATA, 1 = ready for NULL.
- soma  out  2*WIDTH  registered dual-rail sum.
- cout  out  2  registered dual-rail carry-out.
- ack  out  1  upstream acknowledge; equals current phase (1 = holding DATA).
- err  out  1  sticky illegal-code flag.
- stall  out  1  handshake-timeout flag.

Behaviour:
- Rail code per digit, {rail1,rail0}:
  - 00 = NULL
  - 01 = logic 0
  - 10 = logic 1
  - 11 = illegal
- Input set = a, b, opr, mode (2*WIDTH+2 digits).
  - complete: every digit 01 or 10.
  - null: every digit 00.
  - illegal: any digit 11.
- Arithmetic, {c, s} (WIDTH+1 bits):
  - mode=0: a + b + cin.
  - mode=1: a + ~b + cin (caller drives cin=1 for plain a−b).
  - s and c are re-encoded to dual-rail; wrap-around is modulo 2^WIDTH, with carry into cout.
- FSM, two states:
  - S_NULL:
    - soma and cout are all-00; ack=0.
    - Go to S_DATA when complete & !illegal & ack_next==0.
    - On that edge the encoded result is registered into soma/cout and ack←1.
  - S_DATA:
    - soma/cout hold the captured value; ack=1.
    - Go to S_NULL when null & ack_next==1.
    - On that edge soma and cout ← all-00 and ack←0.
- Latency: exactly 1 clk from the cycle the transition condition is true to the new soma/cout/ack.
- Partial inputs (neither complete nor null) hold state; outputs unchanged.
- Complete input with ack_next==1 in S_NULL: hold, no capture (backpressure).
- Input changes while in S_DATA are ignored until the NULL transition; no re-capture.
- Illegal code:
  - err←1 on the next edge.
  - Sticky until rst.
  - The set counts as neither complete nor null, so the state holds.
- Stall counter, width clog2(STALL_MAX+1):
  - Cleared on any state transition.
  - Otherwise increments, saturating, while any input digit is non-NULL or the state is S_DATA.
  - stall = (counter == STALL_MAX), registered.
  - stall clears on the edge after the next transition.
- Reset, any time including mid-token:
  - state←S_NULL; soma←0, cout←2'b00, ack←0, err←0, stall←0, counter←0.
  - Any in-flight token is dropped.
  - rst dominates all other conditions in the same cycle.
- Outputs change only on clk edges; no combinational path from inputs to outputs.

Decomposition:
- Shared package ncl_pkg:
  - DR_NULL=2'b00, DR_ZERO=2'b01, DR_ONE=2'b10, DR_ILL=2'b11.
  - State encoding S_NULL=1'b0, S_DATA=1'b1.
  - Dual-rail encode/decode functions.
- Sub-module ncl_det_nbits (parameter N digits):
  - Takes a 2*N bus; outputs complete, null, illegal.
  - Instantiated once over {mode, opr, b, a}.
- Adder, FSM, stall counter and output registers stay in the top module.

Test Plan (WIDTH=4, STALL_MAX=8):
- Add:
  - Stimulus: a=8'b01011010 (3), b=8'b01100110 (5), opr=01, mode=01, ack_next=0.
  - Response: 1 clk later soma=8'b10010101 (8), cout=01, ack=1.
  - Then all inputs 00 with ack_next=1: 1 clk later soma=0, cout=00, ack=0.
- Subtract:
  - Stimulus: a=5 (8'b01100110), b=3 (8'b01011010), opr=10, mode=10.
  - Response: soma=8'b01011001 (2), cout=10.
- Wrap:
  - Stimulus: a=15 (8'b10101010), b=1 (8'b01010110), opr=01, mode=01.
  - Response: soma=8'b01010101 (0), cout=10.
- Backpressure / partial:
  - Complete add operands with ack_next=1 for 6 clk: ack=0 and soma=0 throughout.
  - Drop ack_next to 0: next edge ack=1 with the correct sum.
  - A partial NULL wave in S_DATA holds ack=1.
- Illegal:
  - Set a[1:0]=11 with the rest complete: err=1 next clk and state stays S_NULL.
  - Restore a legal code: the token proceeds normally, err stays 1 until rst.
- Stall and reset:
  - Complete data with ack_next held 1: stall=1 on the 9th edge and saturates.
  - Release ack_next: stall clears after the transition.
  - Assert rst in S_DATA: next edge soma=0, ack=0, err=0, stall=0.

Source files
------------

// File: rtl/ncl_pkg.sv
// Shared dual-rail (NCL) definitions: rail codes, FSM state encoding and
// single-digit encode/decode helpers.
package ncl_pkg;

   localparam logic [1:0] DR_NULL = 2'b00;
   localparam logic [1:0] DR_ZERO = 2'b01;
   localparam logic [1:0] DR_ONE  = 2'b10;
   localparam logic [1:0] DR_ILL  = 2'b11;

   typedef enum logic {
      S_NULL = 1'b0,
      S_DATA = 1'b1
   } state_t;

   // Binary bit -> dual-rail digit {rail1, rail0}.
   function automatic logic [1:0] dr_enc(input logic bit_v);
      return bit_v ? DR_ONE : DR_ZERO;
   endfunction

   // Dual-rail digit -> binary bit; only meaningful for a legal data code.
   function automatic logic dr_dec(input logic [1:0] dig);
      return dig[1];
   endfunction

endpackage

// File: rtl/ncl_det_nbits.sv
// Completion / NULL / illegal-code detector over an N-digit dual-rail bus.
module ncl_det_nbits
   import ncl_pkg::*;
#(
   parameter int N = 10
) (
   input  logic [2*N-1:0] bus,
   output logic           complete,
   output logic           is_null,
   output logic           illegal
);

   logic [N-1:0] dig_data;
   logic [N-1:0] dig_null;
   logic [N-1:0] dig_ill;

   for (genvar i = 0; i < N; i++) begin : g_dig
      assign dig_data[i] = (bus[2*i+1 -: 2] == DR_ZERO) || (bus[2*i+1 -: 2] == DR_ONE);
      assign dig_null[i] = (bus[2*i+1 -: 2] == DR_NULL);
      assign dig_ill[i]  = (bus[2*i+1 -: 2] == DR_ILL);
   end

   assign complete = &dig_data;
   assign is_null  = &dig_null;
   assign illegal  = |dig_ill;

endmodule

// File: rtl/est_somador_nbits.sv
// Clocked dual-rail adder/subtractor stage with a four-phase DATA/NULL
// handshake, sticky illegal-code flag and handshake stall watchdog.
module est_somador_nbits
   import ncl_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int STALL_MAX = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*WIDTH-1:0] a,
   input  logic [2*WIDTH-1:0] b,
   input  logic [1:0]         opr,
   input  logic [1:0]         mode,
   input  logic               ack_next,
   output logic [2*WIDTH-1:0] soma,
   output logic [1:0]         cout,
   output logic               ack,
   output logic               err,
   output logic               stall
);

   localparam int CW = $clog2(STALL_MAX + 1);

   logic         in_complete;
   logic         in_null;
   logic         in_illegal;

   ncl_det_nbits #(.N(2*WIDTH+2)) u_det (
      .bus      ({mode, opr, b, a}),
      .complete (in_complete),
      .is_null  (in_null),
      .illegal  (in_illegal)
   );

   // Binary view of the operands; only used when the set is complete.
   logic [WIDTH-1:0] a_bin;
   logic [WIDTH-1:0] b_bin;
   logic             cin;
   logic             sub;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH-1:0] sum_dr;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign a_bin[i] = dr_dec(a[2*i+1 -: 2]);
      assign b_bin[i] = dr_dec(b[2*i+1 -: 2]);
      assign sum_dr[2*i+1 -: 2] = dr_enc(sum[i]);
   end

   assign cin = dr_dec(opr);
   assign sub = dr_dec(mode);
   // Subtract is a + ~b + cin; the caller supplies cin=1 for a plain a-b.
   assign sum = {1'b0, a_bin} + {1'b0, (sub ? ~b_bin : b_bin)} + {{WIDTH{1'b0}}, cin};

   state_t state, state_nxt;
   logic   capture;
   logic   release_tok;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_NULL;
      else     state <= state_nxt;
   end

   // Next-state: capture on a complete legal wave, release on a NULL wave,
   // each gated by the downstream phase.
   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      release_tok = 1'b0;
      case (state)
         S_NULL: if (in_complete && !in_illegal && !ack_next) begin
            state_nxt = S_DATA;
            capture   = 1'b1;
         end
         S_DATA: if (in_null && ack_next) begin
            state_nxt   = S_NULL;
            release_tok = 1'b1;
         end
         default: state_nxt = S_NULL;
      endcase
   end

   // Output registers: load the encoded result on capture, return to NULL on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         soma <= '0;
         cout <= DR_NULL;
         ack  <= 1'b0;
      end else if (capture) begin
         soma <= sum_dr;
         cout <= dr_enc(sum[WIDTH]);
         ack  <= 1'b1;
      end else if (release_tok) begin
         soma <= '0;
         cout <= DR_NULL;
         ack  <= 1'b0;
      end
   end

   // Sticky illegal-code flag.
   always_ff @(posedge clk) begin
      if (rst)             err <= 1'b0;
      else if (in_illegal) err <= 1'b1;
   end

   logic [CW-1:0] stall_cnt;

   // Watchdog: counts cycles without a phase change while a token is in
   // flight; stall lags the counter by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         stall     <= 1'b0;
      end else begin
         stall <= (stall_cnt == CW'(STALL_MAX));
         if (capture || release_tok)
            stall_cnt <= '0;
         else if ((!in_null || state == S_DATA) && stall_cnt != CW'(STALL_MAX))
            stall_cnt <= stall_cnt + CW'(1);
      end
   end

endmodule
